// File: rtl/envia_pkg.sv
// envia_pkg: shared definitions for the 8N1 UART transmitter.
//   state_t    - transmitter FSM encoding
//   calc_div   - clk cycles per bit, rounded to nearest
//   cnt_width  - baud counter width for a given divider
package envia_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    function automatic int calc_div(input int clk_freq, input int baud);
        return (clk_freq + baud / 2) / baud;
    endfunction

    // Degenerate dividers are rejected in the top; clamp here so the
    // counter declaration stays legal long enough to report that error.
    function automatic int cnt_width(input int div);
        return (div < 2) ? 1 : $clog2(div);
    endfunction

endpackage

// File: rtl/envia_senal_if.sv
// envia_senal_if: byte handshake between on-board logic and the transmitter.
//   TxD_valid  master -> slave  byte on TxD_data is offered
//   TxD_data   master -> slave  byte to send
//   TxD_ready  slave -> master  holding register empty; transfer on valid & ready
interface envia_senal_if;
    logic       TxD_valid;
    logic [7:0] TxD_data;
    logic       TxD_ready;

    modport master (output TxD_valid, output TxD_data, input TxD_ready);
    modport slave  (input TxD_valid, input TxD_data, output TxD_ready);
endinterface

// File: rtl/generador_baud.sv
// generador_baud: bit-period counter, counts 0..DIV-1 and wraps.
//   clk   in   system clock
//   rst   in   synchronous active-high reset
//   clr   in   restart the count at 0 on the next edge
//   tick  out  high while count == DIV-1 (last cycle of a bit)
module generador_baud
    import envia_pkg::*;
#(
    parameter int DIV = 10
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    output logic tick
);

    localparam int            W    = cnt_width(DIV);
    localparam logic [W-1:0]  LAST = W'(DIV - 1);

    logic [W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q + W'(1);
        if (clr || cnt_q == LAST) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tick = (cnt_q == LAST);

endmodule

// File: rtl/envia_senal.sv
// envia_senal: 8N1 UART transmitter with a one-byte holding register in
// front of the shifter, so a queued byte leaves back-to-back with no idle gap.
//   clk       in   system clock
//   rst       in   synchronous active-high reset
//   bus       slave handshake (TxD_valid, TxD_data, TxD_ready)
//   TxD       out  registered serial line, idles high
//   TxD_busy  out  a frame is being shifted
//
// state | meaning
// IDLE  | line high, waiting for the holding register to fill
// START | driving the start bit (0)
// DATA  | driving shifter[0], bit index 0..7
// STOP  | driving the stop bit (1); reload from holding if full
module envia_senal
    import envia_pkg::*;
#(
    parameter int CLK_FREQ = 50_000_000,
    parameter int BAUD     = 115_200
) (
    input  logic         clk,
    input  logic         rst,
    envia_senal_if.slave bus,
    output logic         TxD,
    output logic         TxD_busy
);

    localparam int DIV = calc_div(CLK_FREQ, BAUD);

    if (DIV < 2) begin : g_div_check
        $error("envia_senal: DIV must be at least 2");
    end

    state_t     state_q, state_d;
    logic [7:0] hold_q, hold_d;
    logic       full_q, full_d;
    logic [7:0] shift_q, shift_d;
    logic [2:0] idx_q, idx_d;
    logic       txd_q, txd_d;
    logic       tick, clr, accept, load;

    assign bus.TxD_ready = ~full_q;
    assign accept        = bus.TxD_valid & ~full_q;
    assign TxD           = txd_q;
    assign TxD_busy      = (state_q != IDLE);

    // Every state change restarts the bit timer so each bit is exactly DIV long.
    assign clr = (state_d != state_q);

    generador_baud #(.DIV(DIV)) u_baud (
        .clk  (clk),
        .rst  (rst),
        .clr  (clr),
        .tick (tick)
    );

    always_comb begin
        state_d = state_q;
        shift_d = shift_q;
        idx_d   = idx_q;
        txd_d   = txd_q;
        load    = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (full_q) begin
                    state_d = START;
                    shift_d = hold_q;
                    load    = 1'b1;
                    txd_d   = 1'b0;
                end
            end
            START: begin
                if (tick) begin
                    state_d = DATA;
                    txd_d   = shift_q[0];
                    idx_d   = 3'd0;
                end
            end
            DATA: begin
                if (tick) begin
                    if (idx_q == 3'd7) begin
                        state_d = STOP;
                        txd_d   = 1'b1;
                    end else begin
                        shift_d = {1'b0, shift_q[7:1]};
                        txd_d   = shift_q[1];
                        idx_d   = idx_q + 3'd1;
                    end
                end
            end
            STOP: begin
                if (tick) begin
                    if (full_q) begin
                        state_d = START;
                        shift_d = hold_q;
                        load    = 1'b1;
                        txd_d   = 1'b0;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // load only happens with full_q set, i.e. ready low, so it never
    // coincides with an accept.
    always_comb begin
        hold_d = hold_q;
        full_d = full_q;
        if (accept) begin
            hold_d = bus.TxD_data;
            full_d = 1'b1;
        end else if (load) begin
            full_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            hold_q  <= '0;
            full_q  <= 1'b0;
            shift_q <= '0;
            idx_q   <= '0;
            txd_q   <= 1'b1;
        end else begin
            state_q <= state_d;
            hold_q  <= hold_d;
            full_q  <= full_d;
            shift_q <= shift_d;
            idx_q   <= idx_d;
            txd_q   <= txd_d;
        end
    end

endmodule
